// File: rtl/func_stream_fetch.sv
// func_stream_fetch: reads `size` WORD_W elements over Avalon-MM (BUS_W beats, little-endian lanes) into a stream FIFO.
// Latency: a word is visible on out_valid right after the edge that completes its last beat (empty FIFO).
// Backpressure: read is held off unless a FIFO slot is free for the word being assembled; out_data holds until popped.
// Optional abort input is compiled in with FUNC_STREAM_FETCH_ABORT_EN.
module func_stream_fetch #(
  parameter int BUS_W      = 16,
  parameter int WORD_W     = 32,
  parameter int FIFO_DEPTH = 8,
  parameter int ADDR_W     = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_ptr,
  input  logic [31:0]       size,
`ifdef FUNC_STREAM_FETCH_ABORT_EN
  input  logic              abort,
`endif
  output logic              busy,
  output logic              done,
  output logic [31:0]       result,
  output logic [ADDR_W-1:0] address,
  output logic              read,
  input  logic [BUS_W-1:0]  readdata,
  input  logic              waitrequest,
  output logic              out_valid,
  output logic [WORD_W-1:0] out_data,
  output logic              out_last,
  input  logic              out_ready
);
  localparam int BEATS  = WORD_W / BUS_W;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FIN} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       size_q, size_d;
  logic [31:0]       elem_q, elem_d;
  logic [31:0]       pop_cnt_q, pop_cnt_d;
  logic [31:0]       result_q, result_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic [WORD_W-1:0] asm_q, asm_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WORD_W:0]   mem_q [FIFO_DEPTH];
  logic              beat_done, word_done, last_word, push, pop, flush;
`ifdef FUNC_STREAM_FETCH_ABORT_EN
  logic              abort_pend_q, abort_pend_d;
`endif

  // The slot check only loosens while waiting (pops), so read stays stable under waitrequest.
  assign read      = (state_q == ISSUE) && (cnt_q < CNT_W'(FIFO_DEPTH));
  assign beat_done = read && !waitrequest;
  assign word_done = beat_done && (beat_q == BEAT_W'(BEATS - 1));
  assign last_word = (elem_q == size_q - 32'd1);
  assign out_valid = (cnt_q != '0);
  assign pop       = out_valid && out_ready;
  assign {out_last, out_data} = mem_q[rd_ptr_q];
  assign busy      = busy_q;
  assign done      = done_q;
  assign result    = result_q;
  assign address   = addr_q;

  // Next-state, beat assembly and FIFO bookkeeping.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    size_d    = size_q;
    elem_d    = elem_q;
    beat_d    = beat_q;
    asm_d     = asm_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    result_d  = result_q;
    pop_cnt_d = pop ? pop_cnt_q + 32'd1 : pop_cnt_q;
    push      = 1'b0;
    flush     = 1'b0;
`ifdef FUNC_STREAM_FETCH_ABORT_EN
    abort_pend_d = abort_pend_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start && !busy_q && !done_q) begin
          addr_d    = base_ptr;
          size_d    = size;
          elem_d    = '0;
          beat_d    = '0;
          pop_cnt_d = '0;
          busy_d    = 1'b1;
          state_d   = (size == 32'd0) ? FIN : ISSUE;
        end
      end
      ISSUE: begin
        if (beat_done) begin
          for (int i = 0; i < BEATS; i++) begin
            if (beat_q == BEAT_W'(i)) asm_d[i*BUS_W +: BUS_W] = readdata;
          end
          addr_d = addr_q + ADDR_W'(BUS_W / 8);
          beat_d = word_done ? '0 : beat_q + BEAT_W'(1);
        end
        if (word_done) begin
          push   = 1'b1;
          elem_d = elem_q + 32'd1;
          if (last_word) state_d = DRAIN;
        end
`ifdef FUNC_STREAM_FETCH_ABORT_EN
        // A stalled beat must finish before the flush; the partial word is discarded.
        if (abort || abort_pend_q) begin
          if (read && waitrequest) begin
            abort_pend_d = 1'b1;
          end else begin
            abort_pend_d = 1'b0;
            push         = 1'b0;
            flush        = 1'b1;
            state_d      = FIN;
          end
        end
`endif
      end
      DRAIN: begin
        if (cnt_q == '0) state_d = FIN;
`ifdef FUNC_STREAM_FETCH_ABORT_EN
        if (abort) begin
          flush   = 1'b1;
          state_d = FIN;
        end
`endif
      end
      FIN: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Result counts words actually accepted downstream, including this cycle's pop.
    if (state_d == FIN && state_q != FIN) result_d = pop_cnt_d;

    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    cnt_d    = cnt_q + CNT_W'(push) - CNT_W'(pop);
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end
  end

  // Control and datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      size_q    <= '0;
      elem_q    <= '0;
      beat_q    <= '0;
      asm_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      result_q  <= '0;
      pop_cnt_q <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
`ifdef FUNC_STREAM_FETCH_ABORT_EN
      abort_pend_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      size_q    <= size_d;
      elem_q    <= elem_d;
      beat_q    <= beat_d;
      asm_q     <= asm_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      result_q  <= result_d;
      pop_cnt_q <= pop_cnt_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
`ifdef FUNC_STREAM_FETCH_ABORT_EN
      abort_pend_q <= abort_pend_d;
`endif
    end
  end

  // FIFO storage; a valid head is never overwritten because writes need a reserved free slot.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else if (push) begin
      mem_q[wr_ptr_q] <= {last_word, asm_d};
    end
  end

endmodule
